adc_capture_ctrl: RTL

ADC_CAPTURE_CTRL -- requirements
Module: adc_capture_ctrl

---
 rtl/adc_cap_pkg.sv | 16 +
 rtl/adc_cap_rr_arb.sv | 44 ++++
 rtl/adc_capture_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/adc_cap_pkg.sv
// Shared sizing constants and the FSM state type for the ADC capture controller.
package adc_cap_pkg;
  localparam int N_CH_DEF   = 3;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 11;
  localparam int BANK_W     = 2;
  localparam int BANK_DEPTH = 512;
  localparam int BANK_AW    = $clog2(BANK_DEPTH);
  localparam int N_BANKS    = 1 << BANK_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } cap_state_t;
endpackage

// File: rtl/adc_cap_rr_arb.sv
// Round-robin arbiter: one-hot grant among pending requests, search starts
// one past the last accepted grant.
module adc_cap_rr_arb
  import adc_cap_pkg::*;
#(
  parameter int N_CH = N_CH_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] req,
  input  logic            advance,
  output logic [N_CH-1:0] grant
);
  localparam int PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [PTR_W-1:0] last;
  logic [PTR_W-1:0] grant_idx;
  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    grant     = '0;
    grant_idx = last;
    idx       = '0;
    found     = 1'b0;
    for (int i = 1; i <= N_CH; i++) begin
      idx = PTR_W'((int'(last) + i) % N_CH);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        found      = 1'b1;
      end
    end
  end

  // The pointer only moves when the top actually consumed the grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= PTR_W'(N_CH - 1);
    end else if (advance && found) begin
      last <= grant_idx;
    end
  end
endmodule

// File: rtl/adc_capture_ctrl.sv
// Captures decimated ADC samples from several channels into four banked
// SRAMs, one word per cycle, in one-shot or circular mode.
module adc_capture_ctrl
  import adc_cap_pkg::*;
#(
  parameter int N_CH   = N_CH_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     start_i,
  input  logic                     stop_i,
  input  logic [N_CH-1:0]          ch_en_i,
  input  logic                     circ_i,
  input  logic [ADDR_W-1:0]        len_i,
  input  logic [N_CH-1:0]          adc_dvalid_i,
  input  logic [N_CH*DATA_W-1:0]   adc_dat_i,
  output logic [N_BANKS-1:0]       mem_wenb_o,
  output logic [BANK_AW-1:0]       mem_waddr_o,
  output logic [DATA_W-1:0]        mem_data_o,
  output logic [3:0]               wmask_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [ADDR_W-1:0]        wr_ptr_o,
  output logic [N_CH-1:0]          ovf_o
);
  cap_state_t        state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [N_CH-1:0]   hold_full;
  logic [N_CH-1:0]   hold_next;
  logic [N_CH-1:0]   valid_en;
  logic [N_CH-1:0]   load;
  logic [N_CH-1:0]   ovf_set;
  logic [N_CH-1:0]   req;
  logic [N_CH-1:0]   grant;
  logic [DATA_W-1:0] hold_data [N_CH];
  logic [DATA_W-1:0] grant_data;
  logic              capture;
  logic              write_en;
  logic              last_word;
  logic [BANK_W-1:0] bank;

  assign capture   = (state == CAPTURE);
  assign valid_en  = adc_dvalid_i & ch_en_i & {N_CH{capture}};
  assign req       = hold_full & {N_CH{capture}};
  assign write_en  = capture && !stop_i && (|grant);
  // A granted hold drains this edge, so it may take a fresh sample without overflowing.
  assign hold_next = (hold_full & ~grant) | valid_en;
  assign load      = valid_en & (~hold_full | grant);
  assign ovf_set   = valid_en & hold_full & ~grant;
  assign last_word = (wr_ptr == len_i);
  assign bank      = wr_ptr[ADDR_W-1 -: BANK_W];
  assign wr_ptr_o  = wr_ptr;

  adc_cap_rr_arb #(
    .N_CH(N_CH)
  ) u_arb (
    .clk    (wb_clk_i),
    .rst    (wb_rst_i),
    .req    (req),
    .advance(write_en),
    .grant  (grant)
  );

  always_comb begin
    grant_data = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (grant[c]) grant_data = hold_data[c];
    end
  end

  always_ff @(posedge wb_clk_i) begin
    for (int c = 0; c < N_CH; c++) begin
      if (load[c]) hold_data[c] <= adc_dat_i[c*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      hold_full   <= '0;
      ovf_o       <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      mem_wenb_o  <= '1;
      wmask_o     <= 4'h0;
      mem_waddr_o <= '0;
      mem_data_o  <= '0;
    end else begin
      done_o     <= 1'b0;
      mem_wenb_o <= '1;
      wmask_o    <= 4'h0;
      case (state)
        IDLE: begin
          if (start_i) begin
            state     <= CAPTURE;
            busy_o    <= 1'b1;
            wr_ptr    <= '0;
            ovf_o     <= '0;
            hold_full <= '0;
          end
        end
        CAPTURE: begin
          if (stop_i) begin
            state     <= IDLE;
            busy_o    <= 1'b0;
            hold_full <= '0;
          end else begin
            hold_full <= hold_next;
            ovf_o     <= ovf_o | ovf_set;
            if (write_en) begin
              mem_wenb_o  <= ~(N_BANKS'(1) << bank);
              mem_waddr_o <= wr_ptr[BANK_AW-1:0];
              mem_data_o  <= grant_data;
              wmask_o     <= 4'hF;
              if (last_word) begin
                done_o <= 1'b1;
                if (circ_i) begin
                  wr_ptr <= '0;
                end else begin
                  wr_ptr    <= wr_ptr + 1'b1;
                  state     <= DONE;
                  busy_o    <= 1'b0;
                  hold_full <= '0;
                end
              end else begin
                wr_ptr <= wr_ptr + 1'b1;
              end
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
